lfsr_noise_shaper: RTL

Downstream consumer of the pseudo-random LFSR data source. Converts each valid LFSR word to a signed sample and sums 2^LOG2_ACC consecutive samples to approximate Gaussian noise (central-limit shaping). Scales the sum by a runtime right-shift and saturates it to the output width. Results go through a 2-entry valid/ready output buffer that feeds the signal-processing chain as a test or dither noise source.

---
 rtl/lfsr_noise_shaper_if.sv | 25 ++
 rtl/lfsr_noise_shaper.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lfsr_noise_shaper_if.sv
// Stream bundle between the LFSR source, the noise shaper and its downstream consumer.
// master = source/sink side driving words and ready; slave = the shaper.
interface lfsr_noise_shaper_if #(
    parameter int NUM_BITS = 16,
    parameter int OUT_BITS = 16
);
    logic                i_Enable;
    logic [NUM_BITS-1:0] i_LFSR_Data;
    logic                i_LFSR_valid;
    logic [4:0]          i_Shift;
    logic [OUT_BITS-1:0] o_Data;
    logic                o_Valid;
    logic                i_Ready;
    logic [15:0]         o_Drop_Count;

    modport master (
        output i_Enable, i_LFSR_Data, i_LFSR_valid, i_Shift, i_Ready,
        input  o_Data, o_Valid, o_Drop_Count
    );

    modport slave (
        input  i_Enable, i_LFSR_Data, i_LFSR_valid, i_Shift, i_Ready,
        output o_Data, o_Valid, o_Drop_Count
    );
endinterface

// File: rtl/lfsr_noise_shaper.sv
// Two-entry valid/ready FIFO with a registered head that holds its last value when empty.
// Latency: push visible on pop side the next cycle. Backpressure: push_rdy low only when full without a pop.
module lfsr_noise_shaper_fifo2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         push_rdy,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat
);
    logic [1:0]   count_q;
    logic [1:0]   count_nxt;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         vld_q;
    logic         pop;
    logic         push;

    assign pop      = vld_q & pop_rdy;
    assign push_rdy = (count_q != 2'd2) | pop;
    assign push     = push_vld & push_rdy;
    assign pop_vld  = vld_q;
    assign pop_dat  = head_q;

    always_comb begin
        count_nxt = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            vld_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_nxt;
            vld_q   <= (count_nxt != 2'd0);
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= push_dat;
                    else                 tail_q <= push_dat;
                end
                2'b01: begin
                    if (count_q == 2'd2) head_q <= tail_q;
                end
                2'b11: begin
                    // Head leaves; with one entry the newcomer becomes head directly.
                    if (count_q == 2'd1) begin
                        head_q <= push_dat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// Sums 2^LOG2_ACC offset-binary LFSR words into approximately Gaussian noise, shifts and saturates it.
// Latency: last sample at cycle N -> result register N+1 -> o_Valid at N+2.
// Backpressure: 2-entry output buffer; results arriving while full and not draining are counted and dropped.
module lfsr_noise_shaper #(
    parameter int NUM_BITS = 16,
    parameter int LOG2_ACC = 2,
    parameter int OUT_BITS = 16
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    lfsr_noise_shaper_if.slave  bus
);
    localparam int ACC_LEN = 1 << LOG2_ACC;
    localparam int ACC_W   = NUM_BITS + LOG2_ACC;
    localparam int CNT_W   = (LOG2_ACC > 0) ? LOG2_ACC : 1;

    localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (OUT_BITS - 1)) - 64'sd1;
    localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (OUT_BITS - 1));

    logic signed [NUM_BITS-1:0] sample;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    sum;
    logic [CNT_W-1:0]           cnt_q;
    logic                       take;
    logic                       last;
    logic signed [63:0]         shifted;
    logic [OUT_BITS-1:0]        sat;

    logic                       res_vld_q;
    logic [OUT_BITS-1:0]        res_q;
    logic                       push_rdy;
    logic [15:0]                drop_q;

    // Flipping the MSB turns offset-binary into two's complement centred on zero.
    assign sample  = {~bus.i_LFSR_Data[NUM_BITS-1], bus.i_LFSR_Data[NUM_BITS-2:0]};
    assign sum     = acc_q + ACC_W'(sample);
    assign take    = bus.i_LFSR_valid & bus.i_Enable;
    assign last    = (cnt_q == CNT_W'(ACC_LEN - 1));
    assign shifted = 64'(sum) >>> bus.i_Shift;

    always_comb begin
        if (shifted > SAT_MAX)      sat = SAT_MAX[OUT_BITS-1:0];
        else if (shifted < SAT_MIN) sat = SAT_MIN[OUT_BITS-1:0];
        else                        sat = shifted[OUT_BITS-1:0];
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (!bus.i_Enable) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (bus.i_LFSR_valid) begin
            if (last) begin
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum;
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Completions are at least one valid sample apart, so this stage never needs to stall.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            res_vld_q <= 1'b0;
            res_q     <= '0;
        end else begin
            res_vld_q <= take & last;
            if (take & last) res_q <= sat;
        end
    end

    lfsr_noise_shaper_fifo2 #(.W(OUT_BITS)) u_out_fifo (
        .clk      (i_Clk),
        .rst_n    (i_Rst_n),
        .push_vld (res_vld_q),
        .push_dat (res_q),
        .push_rdy (push_rdy),
        .pop_vld  (bus.o_Valid),
        .pop_rdy  (bus.i_Ready),
        .pop_dat  (bus.o_Data)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            drop_q <= 16'd0;
        end else if (res_vld_q && !push_rdy && drop_q != 16'hFFFF) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.o_Drop_Count = drop_q;
endmodule
